// File: rtl/bufgctrl_switch_ctrl.sv
// Sequencer for one BUFGCTRL-style glitchless clock mux: disable old side, settle, enable new side, settle.
// Runs on a free-running control clock; optional automatic failover when the selected source stops.
module bufgctrl_switch_ctrl #(
  parameter int INIT_SEL      = 0,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8,
  parameter int AUTO_FAILOVER = 1,
  parameter int DEAD_CYCLES   = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ_VALID,
  input  logic       REQ_SEL,
  output logic       REQ_READY,
  output logic       ACK,
  output logic       ERR,
  output logic       FAILOVER,
  input  logic [1:0] CLK_ALIVE,
  output logic       CUR_SEL,
  output logic       BUSY,
  output logic       CE0,
  output logic       CE1,
  output logic       S0,
  output logic       S1,
  output logic       IGNORE0,
  output logic       IGNORE1
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OFF  = 2'd1;
  localparam logic [1:0] ST_ON   = 2'd2;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEAD_MAX    = CNT_W'(DEAD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic             INIT_BIT    = (INIT_SEL != 0);
  localparam logic             FO_EN       = (AUTO_FAILOVER != 0);

  logic [1:0]       state;
  logic             cur_sel;
  logic             tgt;
  logic             is_fo;
  logic [1:0]       en;
  logic [1:0]       ign;
  logic [CNT_W-1:0] settle_cnt;
  logic [CNT_W-1:0] dead_cnt;
  logic             ack_q;
  logic             err_q;
  logic             fo_q;
  logic             busy_q;

  logic oth_sel;
  logic alive_cur;
  logic alive_oth;
  logic fo_trig;
  logic settle_done;
  logic tgt_dead;

  always_comb begin
    oth_sel     = ~cur_sel;
    alive_cur   = CLK_ALIVE[cur_sel];
    alive_oth   = CLK_ALIVE[oth_sel];
    // Failover pre-empts a request presented in the same cycle.
    fo_trig     = FO_EN && (state == ST_IDLE) && (dead_cnt == DEAD_MAX) && !alive_cur && alive_oth;
    settle_done = (settle_cnt == SETTLE_LAST);
    tgt_dead    = !CLK_ALIVE[tgt];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      cur_sel    <= INIT_BIT;
      tgt        <= INIT_BIT;
      is_fo      <= 1'b0;
      en         <= INIT_BIT ? 2'b10 : 2'b01;
      ign        <= 2'b00;
      settle_cnt <= '0;
      dead_cnt   <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      fo_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      fo_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (FO_EN) begin
            if (alive_cur) begin
              dead_cnt <= '0;
            end else if (dead_cnt != DEAD_MAX) begin
              dead_cnt <= dead_cnt + CNT_ONE;
            end
          end
          if (fo_trig) begin
            state       <= ST_OFF;
            busy_q      <= 1'b1;
            tgt         <= oth_sel;
            is_fo       <= 1'b1;
            en[cur_sel] <= 1'b0;
            ign[cur_sel] <= 1'b1;
            settle_cnt  <= '0;
          end else if (REQ_VALID) begin
            if (REQ_SEL == cur_sel) begin
              ack_q <= 1'b1;
            end else if (!CLK_ALIVE[REQ_SEL]) begin
              ack_q <= 1'b1;
              err_q <= 1'b1;
            end else begin
              state       <= ST_OFF;
              busy_q      <= 1'b1;
              tgt         <= REQ_SEL;
              is_fo       <= 1'b0;
              en[cur_sel] <= 1'b0;
              settle_cnt  <= '0;
            end
          end
        end
        ST_OFF, ST_ON: begin
          if (tgt_dead) begin
            // Abort: fall back to the source that was running before the sequence.
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
            en[tgt]  <= 1'b0;
            en[~tgt] <= 1'b1;
            ign      <= 2'b00;
            dead_cnt <= '0;
            if (!is_fo) begin
              ack_q <= 1'b1;
              err_q <= 1'b1;
            end
          end else if (settle_done) begin
            settle_cnt <= '0;
            if (state == ST_OFF) begin
              state   <= ST_ON;
              en[tgt] <= 1'b1;
            end else begin
              state    <= ST_IDLE;
              busy_q   <= 1'b0;
              cur_sel  <= tgt;
              ign      <= 2'b00;
              dead_cnt <= '0;
              if (is_fo) begin
                fo_q <= 1'b1;
              end else begin
                ack_q <= 1'b1;
              end
            end
          end else begin
            settle_cnt <= settle_cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign REQ_READY = (state == ST_IDLE);
  assign ACK       = ack_q;
  assign ERR       = err_q;
  assign FAILOVER  = fo_q;
  assign CUR_SEL   = cur_sel;
  assign BUSY      = busy_q;
  assign CE0       = en[0];
  assign S0        = en[0];
  assign CE1       = en[1];
  assign S1        = en[1];
  assign IGNORE0   = ign[0];
  assign IGNORE1   = ign[1];

endmodule
